bd_tag_merge_arbiter: RTL and testbench

Arbitrated merge that sequences the two BD-side tag streams (TAT tags and accumulator tags, both produced by the BD input split) onto the single tag channel heading upstream. Arbitration is round-robin with a configurable maximum burst per source, or fixed-priority under a runtime control bit. A 2-entry output buffer decouples the output from the inputs. Per-source saturating word counters support debug readout.

---
 rtl/bd_tag_merge_arbiter.sv | 161 ++++++++++++++++
 tb/tb_bd_tag_merge_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bd_tag_merge_arbiter.sv
// bd_tag_merge_arbiter
// Merges the TAT tag stream (in0) and the accumulator tag stream (in1) onto one
// upstream tag channel. Round-robin with a per-source burst cap, or fixed
// priority to in0. A 2-entry FIFO drives the output from registers only, and
// per-source saturating word counters are kept for debug readout.

module bd_tag_merge_arbiter #(
    parameter int NData    = 20,
    parameter int MaxBurst = 4,
    parameter int CountW   = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NData-1:0]  in0_d,
    input  logic              in0_v,
    output logic              in0_a,
    input  logic [NData-1:0]  in1_d,
    input  logic              in1_v,
    output logic              in1_a,
    output logic [NData-1:0]  out_d,
    output logic              out_v,
    input  logic              out_a,
    input  logic              fixed_prio,
    input  logic              clear_counts,
    output logic [CountW-1:0] word_count0,
    output logic [CountW-1:0] word_count1
);

    localparam int BurstW = $clog2(MaxBurst + 1);
    localparam logic [BurstW-1:0] BurstMax = BurstW'(MaxBurst);
    localparam logic [BurstW-1:0] BurstOne = BurstW'(1);

    logic [1:0]        occ_q, occ_d;
    logic [NData-1:0]  slot0_q, slot0_d;
    logic [NData-1:0]  slot1_q, slot1_d;
    logic              cur_q, cur_d;
    logic [BurstW-1:0] burst_q, burst_d;
    logic [CountW-1:0] cnt0_q, cnt0_d;
    logic [CountW-1:0] cnt1_q, cnt1_d;
    logic              run_q, run_d;

    logic              space;
    logic              grant1;
    logic              acc0;
    logic              acc1;
    logic              push;
    logic              pop;
    logic [NData-1:0]  push_data;

    assign out_v       = (occ_q != 2'd0);
    assign out_d       = slot0_q;
    assign word_count0 = cnt0_q;
    assign word_count1 = cnt1_q;

    // Grant selection and input acks. burst_q==0 only right after reset and
    // means no burst is in progress, so the contest goes to ~cur (in0).
    // run_q holds acks off until the first edge after reset release.
    always_comb begin
        space  = run_q && (occ_q != 2'd2);
        grant1 = 1'b0;
        if (fixed_prio) begin
            grant1 = !in0_v;
        end else if (in0_v && in1_v) begin
            if ((burst_q != '0) && (burst_q < BurstMax)) begin
                grant1 = cur_q;
            end else begin
                grant1 = !cur_q;
            end
        end else begin
            grant1 = in1_v;
        end
        in0_a     = space && in0_v && !grant1;
        in1_a     = space && in1_v && grant1;
        acc0      = in0_a;
        acc1      = in1_a;
        push      = acc0 || acc1;
        pop       = out_v && out_a;
        push_data = acc1 ? in1_d : in0_d;
    end

    // FIFO next state: slot0 is always the head, slot1 the second entry.
    always_comb begin
        occ_d   = occ_q;
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        case ({push, pop})
            2'b10: begin
                if (occ_q == 2'd0) begin
                    slot0_d = push_data;
                end else begin
                    slot1_d = push_data;
                end
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                slot0_d = slot1_q;
                occ_d   = occ_q - 2'd1;
            end
            2'b11: begin
                // Push with pop only happens at occupancy 1 (full blocks push).
                slot0_d = push_data;
            end
            default: begin
            end
        endcase
    end

    // Arbitration history, word counters and the post-reset run flag.
    always_comb begin
        cur_d   = cur_q;
        burst_d = burst_q;
        cnt0_d  = cnt0_q;
        cnt1_d  = cnt1_q;
        run_d   = 1'b1;
        if (push) begin
            if (acc1 == cur_q) begin
                if (burst_q < BurstMax) begin
                    burst_d = burst_q + BurstOne;
                end
            end else begin
                cur_d   = acc1;
                burst_d = BurstOne;
            end
        end
        if (clear_counts) begin
            cnt0_d = '0;
            cnt1_d = '0;
        end else begin
            if (acc0 && (cnt0_q != '1)) begin
                cnt0_d = cnt0_q + CountW'(1);
            end
            if (acc1 && (cnt1_q != '1)) begin
                cnt1_d = cnt1_q + CountW'(1);
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            occ_q   <= 2'd0;
            slot0_q <= '0;
            slot1_q <= '0;
            cur_q   <= 1'b1;
            burst_q <= '0;
            cnt0_q  <= '0;
            cnt1_q  <= '0;
            run_q   <= 1'b0;
        end else begin
            occ_q   <= occ_d;
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            cur_q   <= cur_d;
            burst_q <= burst_d;
            cnt0_q  <= cnt0_d;
            cnt1_q  <= cnt1_d;
            run_q   <= run_d;
        end
    end

endmodule

// File: tb/tb_bd_tag_merge_arbiter.sv
// Testbench for bd_tag_merge_arbiter: directed scenarios followed by a random
// phase, all checked cycle by cycle against a queue-based reference model.

module tb_bd_tag_merge_arbiter;

    localparam int NData    = 20;
    localparam int MaxBurst = 2;
    localparam int CountW   = 3;
    localparam int MaxCount = (1 << CountW) - 1;

    logic              clk = 1'b0;
    logic              reset_n = 1'b1;
    logic [NData-1:0]  in0_d = '0;
    logic              in0_v = 1'b0;
    logic              in0_a;
    logic [NData-1:0]  in1_d = '0;
    logic              in1_v = 1'b0;
    logic              in1_a;
    logic [NData-1:0]  out_d;
    logic              out_v;
    logic              out_a = 1'b0;
    logic              fixed_prio = 1'b0;
    logic              clear_counts = 1'b0;
    logic [CountW-1:0] word_count0;
    logic [CountW-1:0] word_count1;

    bd_tag_merge_arbiter #(
        .NData(NData), .MaxBurst(MaxBurst), .CountW(CountW)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .in0_d(in0_d), .in0_v(in0_v), .in0_a(in0_a),
        .in1_d(in1_d), .in1_v(in1_v), .in1_a(in1_a),
        .out_d(out_d), .out_v(out_v), .out_a(out_a),
        .fixed_prio(fixed_prio), .clear_counts(clear_counts),
        .word_count0(word_count0), .word_count1(word_count1)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Sender queues, model buffer, and words seen leaving the DUT.
    logic [NData-1:0] src0[$];
    logic [NData-1:0] src1[$];
    logic [NData-1:0] mq[$];
    logic [NData-1:0] dut_outs[$];

    int m_cur, m_burst, m_cnt0, m_cnt1;
    bit m_run;
    bit exp_a0, exp_a1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_cur   = 1;
        m_burst = 0;
        m_cnt0  = 0;
        m_cnt1  = 0;
        m_run   = 0;
    endtask

    task automatic drive();
        in0_v = (src0.size() > 0);
        in0_d = in0_v ? src0[0] : '0;
        in1_v = (src1.size() > 0);
        in1_d = in1_v ? src1[0] : '0;
    endtask

    // Which input should be acked this cycle, from the arbitration rules.
    task automatic model_predict();
        bit sp;
        int g;
        sp = m_run && (mq.size() < 2);
        g  = -1;
        if (in0_v && in1_v) begin
            if (fixed_prio) g = 0;
            else if (m_burst > 0 && m_burst < MaxBurst) g = m_cur;
            else g = 1 - m_cur;
        end else if (in0_v) g = 0;
        else if (in1_v) g = 1;
        exp_a0 = sp && (g == 0);
        exp_a1 = sp && (g == 1);
    endtask

    task automatic check_cycle();
        model_predict();
        chk("in0_a", 32'(in0_a), 32'(exp_a0));
        chk("in1_a", 32'(in1_a), 32'(exp_a1));
        chk("out_v", 32'(out_v), 32'(mq.size() > 0));
        if (mq.size() > 0) chk("out_d", 32'(out_d), 32'(mq[0]));
        chk("word_count0", 32'(word_count0), 32'(m_cnt0));
        chk("word_count1", 32'(word_count1), 32'(m_cnt1));
        if (out_v && out_a) dut_outs.push_back(out_d);
    endtask

    task automatic model_edge();
        logic [NData-1:0] w;
        int s;
        if (!reset_n) return;
        if (m_run) begin
            if (mq.size() > 0 && out_a) void'(mq.pop_front());
            if (exp_a0 || exp_a1) begin
                s = exp_a1 ? 1 : 0;
                w = (s == 1) ? src1.pop_front() : src0.pop_front();
                mq.push_back(w);
                if (s == m_cur) begin
                    if (m_burst < MaxBurst) m_burst++;
                end else begin
                    m_cur   = s;
                    m_burst = 1;
                end
            end
            if (clear_counts) begin
                m_cnt0 = 0;
                m_cnt1 = 0;
            end else begin
                if (exp_a0 && m_cnt0 < MaxCount) m_cnt0++;
                if (exp_a1 && m_cnt1 < MaxCount) m_cnt1++;
            end
        end
        m_run = 1;
    endtask

    // One clock: drive, check at negedge, advance model at posedge, return at posedge+1.
    task automatic step();
        drive();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_out_v"}, 32'(out_v), 32'd0);
        chk({tag, "_out_d"}, 32'(out_d), 32'd0);
        chk({tag, "_in0_a"}, 32'(in0_a), 32'd0);
        chk({tag, "_in1_a"}, 32'(in1_a), 32'd0);
        chk({tag, "_cnt0"}, 32'(word_count0), 32'd0);
        chk({tag, "_cnt1"}, 32'(word_count1), 32'd0);
    endtask

    task automatic pulse_reset(input string tag);
        reset_n = 1'b0;
        src0.delete();
        src1.delete();
        model_reset();
        drive();
        #1;
        check_reset_state(tag);
        step();
        step();
        reset_n = 1'b1;
    endtask

    initial begin
        automatic logic [NData-1:0] exp_rr[12] = '{
            20'h0A0, 20'h0A1, 20'h0B0, 20'h0B1, 20'h0A2, 20'h0A3,
            20'h0B2, 20'h0B3, 20'h0A4, 20'h0A5, 20'h0B4, 20'h0B5};
        automatic logic [NData-1:0] exp_bp[3] = '{20'h11, 20'h22, 20'h33};
        int n;

        model_reset();
        #1 reset_n = 1'b0;

        // Reset held with both inputs valid, then the first contest.
        src0.push_back(20'h00001);
        src1.push_back(20'h00002);
        drive();
        #2;
        check_reset_state("rst");
        step();
        step();
        reset_n = 1'b1;
        out_a   = 1'b1;
        for (int i = 0; i < 12 && dut_outs.size() < 2; i++) step();
        chk("first_cnt", 32'(dut_outs.size()), 32'd2);
        if (dut_outs.size() >= 2) begin
            chk("first_word", 32'(dut_outs[0]), 32'h00001);
            chk("second_word", 32'(dut_outs[1]), 32'h00002);
        end

        // Round-robin bursts of two at one word per cycle.
        pulse_reset("rr_rst");
        dut_outs.delete();
        for (int i = 0; i < 6; i++) begin
            src0.push_back(NData'(32'h0A0 + i));
            src1.push_back(NData'(32'h0B0 + i));
        end
        out_a = 1'b1;
        n = 0;
        while (n < 30 && dut_outs.size() < 12) begin
            step();
            n++;
        end
        chk("rr_steps", 32'(n), 32'd14);
        chk("rr_count", 32'(dut_outs.size()), 32'd12);
        for (int i = 0; i < 12 && i < dut_outs.size(); i++)
            chk($sformatf("rr_word%0d", i), 32'(dut_outs[i]), 32'(exp_rr[i]));
        chk("rr_wc0", 32'(word_count0), 32'd6);
        chk("rr_wc1", 32'(word_count1), 32'd6);

        // Backpressure: two accepted, the third held until the output drains.
        out_a = 1'b0;
        dut_outs.delete();
        src0.push_back(20'h11);
        src0.push_back(20'h22);
        src0.push_back(20'h33);
        for (int i = 0; i < 4; i++) step();
        drive();
        #1;
        chk("bp_hold_a", 32'(in0_a), 32'd0);
        chk("bp_head", 32'(out_d), 32'h11);
        out_a = 1'b1;
        for (int i = 0; i < 10 && dut_outs.size() < 3; i++) step();
        chk("bp_count", 32'(dut_outs.size()), 32'd3);
        for (int i = 0; i < 3 && i < dut_outs.size(); i++)
            chk($sformatf("bp_word%0d", i), 32'(dut_outs[i]), 32'(exp_bp[i]));

        // Fixed priority: in0 monopolises while valid, in1 follows immediately.
        fixed_prio = 1'b1;
        dut_outs.delete();
        for (int i = 0; i < 10; i++) src0.push_back(NData'(32'h100 + i));
        for (int i = 0; i < 5; i++) src1.push_back(NData'(32'h200 + i));
        for (int i = 0; i < 40 && dut_outs.size() < 15; i++) step();
        chk("fp_count", 32'(dut_outs.size()), 32'd15);
        for (int i = 0; i < 10 && i < dut_outs.size(); i++)
            chk($sformatf("fp_word%0d", i), 32'(dut_outs[i]), 32'h100 + 32'(i));
        if (dut_outs.size() > 10) chk("fp_handover", 32'(dut_outs[10]), 32'h200);
        fixed_prio = 1'b0;

        // Counter saturation, then clear coinciding with an accept.
        clear_counts = 1'b1;
        step();
        clear_counts = 1'b0;
        for (int i = 0; i < 9; i++) src1.push_back(NData'(32'h500 + i));
        for (int i = 0; i < 30 && src1.size() > 0; i++) step();
        step();
        step();
        chk("sat_wc1", 32'(word_count1), 32'd7);
        chk("sat_wc0", 32'(word_count0), 32'd0);
        for (int i = 0; i < 4; i++) src1.push_back(NData'(32'h600 + i));
        clear_counts = 1'b1;
        drive();
        @(negedge clk);
        check_cycle();
        chk("clr_acc_a", 32'(in1_a), 32'd1);
        @(posedge clk);
        model_edge();
        #1;
        clear_counts = 1'b0;
        chk("clr_wc1", 32'(word_count1), 32'd0);
        for (int i = 0; i < 10 && src1.size() > 0; i++) step();
        step();
        step();

        // Reset with two words buffered: they vanish and in0 wins afterwards.
        out_a = 1'b0;
        src0.push_back(20'h301);
        src0.push_back(20'h302);
        src0.push_back(20'h303);
        for (int i = 0; i < 10 && mq.size() < 2; i++) step();
        chk("mid_full", 32'(out_v), 32'd1);
        pulse_reset("mid_rst");
        dut_outs.delete();
        src0.push_back(20'h401);
        src1.push_back(20'h402);
        out_a = 1'b1;
        for (int i = 0; i < 10 && dut_outs.size() < 2; i++) step();
        chk("mid_count", 32'(dut_outs.size()), 32'd2);
        if (dut_outs.size() >= 2) begin
            chk("mid_first", 32'(dut_outs[0]), 32'h401);
            chk("mid_second", 32'(dut_outs[1]), 32'h402);
        end

        // Random traffic, backpressure, priority mode and clears.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) != 0 && src0.size() < 4) src0.push_back(NData'($urandom));
            if ($urandom_range(0, 2) != 0 && src1.size() < 4) src1.push_back(NData'($urandom));
            out_a        = ($urandom_range(0, 3) != 0);
            clear_counts = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 19) == 0) fixed_prio = ~fixed_prio;
            step();
        end
        out_a        = 1'b1;
        clear_counts = 1'b0;
        fixed_prio   = 1'b0;
        for (int i = 0; i < 30; i++) step();
        chk("drain_empty", 32'(out_v), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
